bus_capture_6502: RTL and testbench
===================================

Name: bus_capture_6502

Overview:
- Front-end stage between the raw 6502 bus pins and the register-file interface. Runs entirely on the internal 50 MHz clock.
- Synchronises the external 1 MHz phi2, chip select and write enable, and detects phi2 edges.
- Converts each selected bus cycle into clean single-cycle write/read strobes with a latched address and data for the downstream register block.
- Generates the data-bus drive enable for reads.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronisers on clk_ext1, cs, wren (legal 2..4).
- SETTLE_CYC, 20, clk_int50 cycles after detected phi2 rise before write data is sampled (legal 4..63).

Ports:
- clk_int50  input  1  internal 50 MHz clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clk_ext1  input  1  external 6502 phi2 (1 MHz), asynchronous to clk_int50.
- cs  input  1  chip select, active low, asynchronous.
- rs  input  4  register select (address), asynchronous.
- wren  input  1  write enable, active low (6502 R/W: 0 = write), asynchronous.
- data_in  input  8  data bus input side.
- addr  output  4  latched register address.
- wdata  output  8  latched write data.
- wr_stb  output  1  one-cycle pulse: wdata/addr valid, commit write.
- rd_stb  output  1  one-cycle pulse: read requested at addr.
- drive_en  output  1  high while the data bus is to be driven for a read.
- abort_err  output  1  sticky: a bus cycle ended before its write was sampled.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, settle counter 0, synchroniser chains cleared to 0. A reset mid-cycle discards the cycle: no strobe, drive_en drops immediately.
- Synchronisers: clk_ext1, cs, wren each pass through SYNC_STAGES flops. rs and data_in pass through one register stage only; they are stable when sampled.
- Edge detection: phi2_rise = sync high and previous sync low; phi2_fall = the reverse.
- State machine:
  - IDLE: on phi2_rise with synced cs == 0, latch addr <= registered rs and latch is_write <= ~synced wren.
    - If write: go to WSETTLE with counter 0.
    - If read: pulse rd_stb the same cycle addr updates (rd_stb high exactly one cycle, addr valid from that cycle), set drive_en = 1, go to RHOLD.
    - phi2_rise with cs == 1: stay in IDLE, no outputs change.
  - WSETTLE: counter increments each cycle. When counter == SETTLE_CYC-1: wdata <= registered data_in, pulse wr_stb one cycle, go to WAIT_FALL. If phi2_fall arrives first: set abort_err, no wr_stb, go to IDLE.
  - RHOLD: drive_en held at 1; on phi2_fall: drive_en <= 0, go to IDLE.
  - WAIT_FALL: on phi2_fall go to IDLE.
- cs/wren changes after the phi2_rise that started a cycle are ignored until the next IDLE.
- phi2_rise seen outside IDLE (glitch or missing fall): ignored. The state machine cannot start a new cycle without passing through IDLE.
- abort_err is cleared only by rst.
- Latency from the real phi2 rise edge:
  - rd_stb: SYNC_STAGES+1 clk_int50 cycles.
  - wr_stb: SYNC_STAGES+SETTLE_CYC cycles.
- addr and wdata hold their values until the next accepted cycle.

Optional Feature:
- Macro BUS_CAPTURE_STATS_EN.
- When defined: adds output wr_count (16 bits), reset to 0, incremented on every wr_stb, wraps 0xFFFF -> 0x0000. Also adds output rd_count (16 bits) with the same rules on rd_stb.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Write cycle, defaults: phi2 1 MHz 50% duty, cs=0, wren=0, rs=0x4, data_in=0xA5 stable during phi2 high -> exactly one wr_stb, 22 cycles after phi2 rise, with addr=0x4 and wdata=0xA5. rd_stb and drive_en stay 0.
- Read cycle: cs=0, wren=1, rs=0xF -> rd_stb one cycle, 3 cycles after phi2 rise, with addr=0xF. drive_en high from that cycle until 2–3 cycles after phi2 fall. No wr_stb.
- Deselected cycle: cs=1, wren=0 for 5 phi2 periods -> no strobes, addr/wdata unchanged, abort_err=0.
- Short phi2 high phase of 200 ns (10 cycles) during a write -> no wr_stb, abort_err=1. abort_err stays 1 through a following good write, which still strobes normally.
- rst pulsed 8 cycles into WSETTLE -> all outputs 0 immediately, no wr_stb for that cycle. The next full write cycle with rs=0x1, data=0x3C strobes correctly.
- BUS_CAPTURE_STATS_EN defined: wr_count preloaded near wrap by driving 65537 writes -> wr_count reads 0x0001. rd_count counts 3 after 3 reads.

Source files
------------

// File: rtl/bus_capture_6502_if.sv
// ============================================================================
// Module   : bus_capture_6502_if
// Brief    : 6502 bus pins and register-file side signals of bus_capture_6502.
//            Optional macro BUS_CAPTURE_STATS_EN adds wr_count / rd_count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_capture_6502_if;
  logic       clk_ext1;
  logic       cs;
  logic       wren;
  logic [3:0] rs;
  logic [7:0] data_in;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       wr_stb;
  logic       rd_stb;
  logic       drive_en;
  logic       abort_err;
`ifdef BUS_CAPTURE_STATS_EN
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  modport master (
    output clk_ext1, cs, wren, rs, data_in,
    input  addr, wdata, wr_stb, rd_stb, drive_en, abort_err, wr_count, rd_count
  );
  modport slave (
    input  clk_ext1, cs, wren, rs, data_in,
    output addr, wdata, wr_stb, rd_stb, drive_en, abort_err, wr_count, rd_count
  );
`else
  modport master (
    output clk_ext1, cs, wren, rs, data_in,
    input  addr, wdata, wr_stb, rd_stb, drive_en, abort_err
  );
  modport slave (
    input  clk_ext1, cs, wren, rs, data_in,
    output addr, wdata, wr_stb, rd_stb, drive_en, abort_err
  );
`endif
endinterface

`default_nettype wire

// File: rtl/bus_capture_6502.sv
// ============================================================================
// Module   : bus_capture_6502
// Brief    : Synchronises 6502 phi2/cs/wren into clk_int50 and turns each
//            selected bus cycle into single-cycle wr_stb / rd_stb strobes.
//            Optional macro BUS_CAPTURE_STATS_EN adds write/read counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_capture_6502 #(
  parameter int SYNC_STAGES = 2,   // legal 2..4
  parameter int SETTLE_CYC  = 20   // legal 4..63
) (
  input  wire logic         clk_int50,
  input  wire logic         rst,
  bus_capture_6502_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WSETTLE   = 2'd1,
    S_RHOLD     = 2'd2,
    S_WAIT_FALL = 2'd3
  } state_t;

  // Counter runs from 0 after the detected rise; strobe fires when its next
  // value reaches SETTLE_CYC-1, i.e. SETTLE_CYC cycles after the rise is seen.
  localparam logic [5:0] c_SETTLE_LAST = 6'(SETTLE_CYC - 1);

  logic [SYNC_STAGES-1:0] r_phi2_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_wren_sync;
  logic                   r_phi2_prev;
  logic [3:0]             r_rs;
  logic [7:0]             r_data;

  state_t     r_state;
  logic [5:0] r_settle_cnt;
  logic [3:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_wr_stb;
  logic       r_rd_stb;
  logic       r_drive_en;
  logic       r_abort_err;

  logic       w_phi2_s;
  logic       w_cs_s;
  logic       w_wren_s;
  logic       w_phi2_rise;
  logic       w_phi2_fall;
  logic [5:0] w_cnt_inc;

  always_ff @(posedge clk_int50 or posedge rst) begin
    if (rst) begin
      r_phi2_sync <= '0;
      r_cs_sync   <= '0;
      r_wren_sync <= '0;
      r_phi2_prev <= 1'b0;
      r_rs        <= 4'd0;
      r_data      <= 8'd0;
    end else begin
      r_phi2_sync <= {r_phi2_sync[SYNC_STAGES-2:0], bus.clk_ext1};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bus.cs};
      r_wren_sync <= {r_wren_sync[SYNC_STAGES-2:0], bus.wren};
      r_phi2_prev <= w_phi2_s;
      r_rs        <= bus.rs;
      r_data      <= bus.data_in;
    end
  end

  assign w_phi2_s    = r_phi2_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_wren_s    = r_wren_sync[SYNC_STAGES-1];
  assign w_phi2_rise =  w_phi2_s & ~r_phi2_prev;
  assign w_phi2_fall = ~w_phi2_s &  r_phi2_prev;
  assign w_cnt_inc   = r_settle_cnt + 6'd1;

  always_ff @(posedge clk_int50 or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= 6'd0;
      r_addr       <= 4'd0;
      r_wdata      <= 8'd0;
      r_wr_stb     <= 1'b0;
      r_rd_stb     <= 1'b0;
      r_drive_en   <= 1'b0;
      r_abort_err  <= 1'b0;
    end else begin
      r_wr_stb <= 1'b0;
      r_rd_stb <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // cs/wren are only looked at here, so later changes in a cycle are ignored
          if (w_phi2_rise && !w_cs_s) begin
            r_addr <= r_rs;
            if (!w_wren_s) begin
              r_settle_cnt <= 6'd0;
              r_state      <= S_WSETTLE;
            end else begin
              r_rd_stb   <= 1'b1;
              r_drive_en <= 1'b1;
              r_state    <= S_RHOLD;
            end
          end
        end
        S_WSETTLE: begin
          r_settle_cnt <= w_cnt_inc;
          if (w_cnt_inc == c_SETTLE_LAST) begin
            r_wdata  <= r_data;
            r_wr_stb <= 1'b1;
            r_state  <= S_WAIT_FALL;
          end else if (w_phi2_fall) begin
            r_abort_err <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_RHOLD: begin
          if (w_phi2_fall) begin
            r_drive_en <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_WAIT_FALL: begin
          if (w_phi2_fall) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_drive_en <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.addr      = r_addr;
  assign bus.wdata     = r_wdata;
  assign bus.wr_stb    = r_wr_stb;
  assign bus.rd_stb    = r_rd_stb;
  assign bus.drive_en  = r_drive_en;
  assign bus.abort_err = r_abort_err;

`ifdef BUS_CAPTURE_STATS_EN
  logic [15:0] r_wr_count;
  logic [15:0] r_rd_count;

  always_ff @(posedge clk_int50 or posedge rst) begin
    if (rst) begin
      r_wr_count <= 16'd0;
      r_rd_count <= 16'd0;
    end else begin
      if (r_wr_stb) r_wr_count <= r_wr_count + 16'd1;
      if (r_rd_stb) r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign bus.wr_count = r_wr_count;
  assign bus.rd_count = r_rd_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_capture_6502.sv
// ============================================================================
// Module   : tb_bus_capture_6502
// Brief    : Directed self-checking bench for bus_capture_6502 (defaults).
//            Honours BUS_CAPTURE_STATS_EN for the counter checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_capture_6502;

  logic clk_int50 = 1'b0;
  logic rst       = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  bus_capture_6502_if bus ();

  bus_capture_6502 #(
    .SYNC_STAGES(2),
    .SETTLE_CYC (20)
  ) dut (
    .clk_int50(clk_int50),
    .rst      (rst),
    .bus      (bus)
  );

  always #10 clk_int50 = ~clk_int50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One phi2 period: hi cycles high then lo cycles low, edge index k counted
  // from the first clk_int50 rising edge that sees phi2 high.
  task automatic run_cycle(input logic sel, input logic wr, input logic [3:0] r,
                           input logic [7:0] d, input int hi, input int lo,
                           output int wr_n, output int wr_at, output int rd_n,
                           output int rd_at, output int de_first, output int de_last,
                           output logic [3:0] a_stb);
    wr_n = 0; wr_at = -1; rd_n = 0; rd_at = -1; de_first = -1; de_last = -1; a_stb = 4'hx;
    @(negedge clk_int50);
    bus.cs = ~sel; bus.wren = ~wr; bus.rs = r; bus.data_in = d; bus.clk_ext1 = 1'b1;
    for (int k = 1; k <= hi + lo; k++) begin
      @(posedge clk_int50); #1;
      if (bus.wr_stb)   begin wr_n++; wr_at = k; a_stb = bus.addr; end
      if (bus.rd_stb)   begin rd_n++; rd_at = k; a_stb = bus.addr; end
      if (bus.drive_en) begin if (de_first < 0) de_first = k; de_last = k; end
      if (k == hi) begin @(negedge clk_int50); bus.clk_ext1 = 1'b0; end
    end
    @(negedge clk_int50);
    bus.cs = 1'b1; bus.wren = 1'b1;
  endtask

  initial begin
    int wr_n, wr_at, rd_n, rd_at, de_first, de_last, sum_n;
    logic [3:0] a_stb;

    bus.clk_ext1 = 1'b0; bus.cs = 1'b1; bus.wren = 1'b1;
    bus.rs = 4'h0; bus.data_in = 8'h00;
    repeat (3) @(posedge clk_int50);
    #1;
    check_eq("rst_addr",  {28'd0, bus.addr},  32'h0);
    check_eq("rst_wdata", {24'd0, bus.wdata}, 32'h0);
    check_eq("rst_strobes_drive_abort",
             {28'd0, bus.wr_stb, bus.rd_stb, bus.drive_en, bus.abort_err}, 32'h0);
    @(negedge clk_int50); rst = 1'b0;
    repeat (3) @(negedge clk_int50);

    // Full-rate write
    run_cycle(1'b1, 1'b1, 4'h4, 8'hA5, 25, 25, wr_n, wr_at, rd_n, rd_at, de_first, de_last, a_stb);
    check_eq("wr_count_pulses", wr_n, 1);
    check_eq("wr_latency",      wr_at, 22);
    check_eq("wr_addr",         {28'd0, a_stb}, 32'h4);
    check_eq("wr_wdata",        {24'd0, bus.wdata}, 32'hA5);
    check_eq("wr_no_rd",        rd_n, 0);
    check_eq("wr_no_drive",     de_first, -1);

    // Read
    run_cycle(1'b1, 1'b0, 4'hF, 8'h00, 25, 25, wr_n, wr_at, rd_n, rd_at, de_first, de_last, a_stb);
    check_eq("rd_pulses",      rd_n, 1);
    check_eq("rd_latency",     rd_at, 3);
    check_eq("rd_addr",        {28'd0, a_stb}, 32'hF);
    check_eq("rd_drive_first", de_first, 3);
    check_eq("rd_drive_last",  de_last, 27);
    check_eq("rd_no_wr",       wr_n, 0);

    // Deselected cycles leave everything untouched
    sum_n = 0;
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b0, 1'b1, 4'h7, 8'h55, 25, 25, wr_n, wr_at, rd_n, rd_at, de_first, de_last, a_stb);
      sum_n += wr_n + rd_n + ((de_first >= 0) ? 1 : 0);
    end
    check_eq("desel_no_activity", sum_n, 0);
    check_eq("desel_addr",        {28'd0, bus.addr},  32'hF);
    check_eq("desel_wdata",       {24'd0, bus.wdata}, 32'hA5);
    check_eq("desel_abort",       {31'd0, bus.abort_err}, 32'h0);

    // Short high phase aborts the write
    run_cycle(1'b1, 1'b1, 4'h9, 8'h11, 10, 40, wr_n, wr_at, rd_n, rd_at, de_first, de_last, a_stb);
    check_eq("short_no_wr", wr_n, 0);
    check_eq("short_abort", {31'd0, bus.abort_err}, 32'h1);
    check_eq("short_wdata", {24'd0, bus.wdata}, 32'hA5);

    // Good write after abort: strobes normally, abort stays sticky
    run_cycle(1'b1, 1'b1, 4'h2, 8'h99, 25, 25, wr_n, wr_at, rd_n, rd_at, de_first, de_last, a_stb);
    check_eq("post_abort_wr_latency", wr_at, 22);
    check_eq("post_abort_addr",       {28'd0, a_stb}, 32'h2);
    check_eq("post_abort_wdata",      {24'd0, bus.wdata}, 32'h99);
    check_eq("post_abort_sticky",     {31'd0, bus.abort_err}, 32'h1);

`ifdef BUS_CAPTURE_STATS_EN
    for (int i = 0; i < 2; i++)
      run_cycle(1'b1, 1'b0, 4'h3, 8'h00, 25, 25, wr_n, wr_at, rd_n, rd_at, de_first, de_last, a_stb);
    check_eq("stats_wr_count", {16'd0, bus.wr_count}, 32'd2);
    check_eq("stats_rd_count", {16'd0, bus.rd_count}, 32'd3);
`endif

    // Reset 8 cycles into the settle window
    @(negedge clk_int50);
    bus.cs = 1'b0; bus.wren = 1'b0; bus.rs = 4'h6; bus.data_in = 8'h77; bus.clk_ext1 = 1'b1;
    wr_n = 0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk_int50); #1;
      if (bus.wr_stb) wr_n++;
    end
    @(negedge clk_int50);
    rst = 1'b1; bus.clk_ext1 = 1'b0;
    #1;
    check_eq("midrst_outputs_zero",
             {16'd0, bus.addr, bus.wdata, bus.wr_stb, bus.rd_stb, bus.drive_en, bus.abort_err},
             32'h0);
    repeat (3) @(negedge clk_int50);
    rst = 1'b0; bus.cs = 1'b1; bus.wren = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk_int50); #1;
      if (bus.wr_stb) wr_n++;
    end
    check_eq("midrst_no_wr", wr_n, 0);

    run_cycle(1'b1, 1'b1, 4'h1, 8'h3C, 25, 25, wr_n, wr_at, rd_n, rd_at, de_first, de_last, a_stb);
    check_eq("after_rst_wr_pulses",  wr_n, 1);
    check_eq("after_rst_wr_latency", wr_at, 22);
    check_eq("after_rst_addr",       {28'd0, a_stb}, 32'h1);
    check_eq("after_rst_wdata",      {24'd0, bus.wdata}, 32'h3C);
    check_eq("after_rst_abort",      {31'd0, bus.abort_err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
